// File: rtl/hdmi_pack_gen.sv
// hdmi_pack_gen: video timing generator with a pixel request handshake and a
// packed output word {clk, hsync, vsync, de, r, g, b, x, y}.
// Timing fields travel two register stages so they line up with the colour
// that the source returns one cycle after req.
module hdmi_pack_gen #(
    parameter int unsigned H_ACT  = 1280,
    parameter int unsigned V_ACT  = 720,
    parameter int unsigned H_FP   = 110,
    parameter int unsigned H_SYNC = 40,
    parameter int unsigned H_BP   = 220,
    parameter int unsigned V_FP   = 5,
    parameter int unsigned V_SYNC = 5,
    parameter int unsigned V_BP   = 20,
    parameter bit          HS_POL = 1'b1,
    parameter bit          VS_POL = 1'b1,
    localparam int unsigned XW    = $clog2(H_ACT),
    localparam int unsigned YW    = $clog2(V_ACT),
    localparam int unsigned W     = 3*8 + 4 + XW + YW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic         req,
    input  logic [7:0]   r_in,
    input  logic [7:0]   g_in,
    input  logic [7:0]   b_in,
    output logic         frame_start,
    output logic [W-1:0] pack
);

    localparam int unsigned H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int unsigned HCW   = $clog2(H_TOT);
    localparam int unsigned VCW   = $clog2(V_TOT);

    localparam logic [HCW-1:0] H_LAST   = HCW'(H_TOT - 1);
    localparam logic [HCW-1:0] H_ACT_C  = HCW'(H_ACT);
    localparam logic [HCW-1:0] H_HS_BEG = HCW'(H_ACT + H_FP);
    localparam logic [HCW-1:0] H_HS_END = HCW'(H_ACT + H_FP + H_SYNC);
    localparam logic [VCW-1:0] V_LAST   = VCW'(V_TOT - 1);
    localparam logic [VCW-1:0] V_ACT_C  = VCW'(V_ACT);
    localparam logic [VCW-1:0] V_VS_BEG = VCW'(V_ACT + V_FP);
    localparam logic [VCW-1:0] V_VS_END = VCW'(V_ACT + V_FP + V_SYNC);

    logic [HCW-1:0] r_h_cnt;
    logic [VCW-1:0] r_v_cnt;

    logic           w_run;
    logic           w_de;
    logic           w_fs;
    logic           w_hs;
    logic           w_vs;
    logic [XW-1:0]  w_x;
    logic [YW-1:0]  w_y;

    logic           r_s1_hs;
    logic           r_s1_vs;
    logic           r_s1_de;
    logic [XW-1:0]  r_s1_x;
    logic [YW-1:0]  r_s1_y;

    logic           r_s2_hs;
    logic           r_s2_vs;
    logic           r_s2_de;
    logic [XW-1:0]  r_s2_x;
    logic [YW-1:0]  r_s2_y;
    logic [7:0]     r_r;
    logic [7:0]     r_g;
    logic [7:0]     r_b;

    // Raster counters: cleared by reset or when disabled, otherwise scan the frame.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + VCW'(1);
        end else begin
            r_h_cnt <= r_h_cnt + HCW'(1);
        end
    end

    // Timing decode from the current counter position.
    always_comb begin
        w_run = en & ~rst;
        w_de  = w_run && (r_h_cnt < H_ACT_C) && (r_v_cnt < V_ACT_C);
        w_fs  = w_run && (r_h_cnt == '0) && (r_v_cnt == '0);
        w_hs  = ((r_h_cnt >= H_HS_BEG) && (r_h_cnt < H_HS_END)) ? HS_POL : ~HS_POL;
        w_vs  = ((r_v_cnt >= V_VS_BEG) && (r_v_cnt < V_VS_END)) ? VS_POL : ~VS_POL;
        w_x   = w_de ? XW'(r_h_cnt) : '0;
        w_y   = w_de ? YW'(r_v_cnt) : '0;
    end

    assign req         = w_de;
    assign frame_start = w_fs;

    // First timing stage: lines up with the cycle the source drives colour.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_hs <= ~HS_POL;
            r_s1_vs <= ~VS_POL;
            r_s1_de <= 1'b0;
            r_s1_x  <= '0;
            r_s1_y  <= '0;
        end else begin
            r_s1_hs <= w_hs;
            r_s1_vs <= w_vs;
            r_s1_de <= w_de;
            r_s1_x  <= w_x;
            r_s1_y  <= w_y;
        end
    end

    // Second stage: timing plus colour captured once, blanked outside active video.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_hs <= ~HS_POL;
            r_s2_vs <= ~VS_POL;
            r_s2_de <= 1'b0;
            r_s2_x  <= '0;
            r_s2_y  <= '0;
            r_r     <= '0;
            r_g     <= '0;
            r_b     <= '0;
        end else begin
            r_s2_hs <= r_s1_hs;
            r_s2_vs <= r_s1_vs;
            r_s2_de <= r_s1_de;
            r_s2_x  <= r_s1_x;
            r_s2_y  <= r_s1_y;
            r_r     <= r_s1_de ? r_in : 8'h00;
            r_g     <= r_s1_de ? g_in : 8'h00;
            r_b     <= r_s1_de ? b_in : 8'h00;
        end
    end

    // The clk field is the live pixel clock; everything else is registered.
    assign pack = {clk, r_s2_hs, r_s2_vs, r_s2_de, r_r, r_g, r_b, r_s2_x, r_s2_y};

endmodule

// File: tb/tb_hdmi_pack_gen.sv
// Randomised and directed bench for hdmi_pack_gen with a raster-position model.
module tb_hdmi_pack_gen;

    localparam int unsigned HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int unsigned VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int unsigned HT = HA + HF + HS + HB;
    localparam int unsigned VT = VA + VF + VS + VB;
    localparam bit HPOL = 1'b1, VPOL = 1'b1;
    localparam int unsigned XW = $clog2(HA);
    localparam int unsigned YW = $clog2(VA);
    localparam int unsigned W  = 3*8 + 4 + XW + YW;
    localparam int NCYC = 3000;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         req;
    logic [7:0]   r_in, g_in, b_in;
    logic         frame_start;
    logic [W-1:0] pack;

    hdmi_pack_gen #(
        .H_ACT(HA), .V_ACT(VA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .HS_POL(HPOL), .VS_POL(VPOL)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .frame_start(frame_start), .pack(pack)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit hs, vs, de, fs;
        int x, y;
    } tim_t;

    tim_t        tim   [NCYC];
    bit          rst_h [NCYC];
    logic [23:0] rgb_h [NCYC];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, k, act, exp);
        else
            n_pass++;
    endtask

    // Clock field must follow the live clock while it is low.
    initial begin
        #1002;
        check("pack_clk_low", 1002, 64'(pack[W-1]), 64'd0);
    end

    initial begin
        int hc, vc;
        bit en_hold;
        bit rk, ek;
        logic [23:0] rgbk;
        logic [W-1:0] exp_pack;
        tim_t t;

        hc = 0; vc = 0; en_hold = 1'b1;
        rst = 1'b1; en = 1'b0; r_in = '0; g_in = '0; b_in = '0;

        for (int k = 0; k < NCYC; k++) begin
            // stimulus for cycle k
            if (k < 120) begin
                rk = (k < 3) || (k >= 67 && k <= 69);
                ek = (k >= 3) && !(k >= 61 && k <= 65);
                if (k >= 1 && tim[k-1].de)
                    rgbk = {8'h10 + 8'(tim[k-1].x), 8'h20 + 8'(tim[k-1].x), 8'h30 + 8'(tim[k-1].x)};
                else
                    rgbk = 24'hFFFFFF;
            end else begin
                if ($urandom_range(0, 199) == 0) en_hold = ~en_hold;
                rk   = ($urandom_range(0, 299) == 0);
                ek   = en_hold;
                rgbk = 24'($urandom);
            end
            rst = rk; en = ek;
            {r_in, g_in, b_in} = rgbk;
            #1;

            // model of what the raster position implies this cycle
            t.de = ek && !rk && hc < int'(HA) && vc < int'(VA);
            t.fs = ek && !rk && hc == 0 && vc == 0;
            t.hs = (hc >= int'(HA + HF) && hc < int'(HA + HF + HS)) ? HPOL : !HPOL;
            t.vs = (vc >= int'(VA + VF) && vc < int'(VA + VF + VS)) ? VPOL : !VPOL;
            t.x  = t.de ? hc : 0;
            t.y  = t.de ? vc : 0;
            tim[k] = t; rst_h[k] = rk; rgb_h[k] = rgbk;

            if (k >= 3) begin
                check("req", k, 64'(req), 64'(t.de));
                check("frame_start", k, 64'(frame_start), 64'(t.fs));
                if (rst_h[k-1] || rst_h[k-2])
                    exp_pack = {1'b1, !HPOL, !VPOL, 1'b0, 24'h0, XW'(0), YW'(0)};
                else
                    exp_pack = {1'b1, tim[k-2].hs, tim[k-2].vs, tim[k-2].de,
                                tim[k-2].de ? rgb_h[k-1] : 24'h0,
                                XW'(tim[k-2].x), YW'(tim[k-2].y)};
                check("pack", k, 64'(pack), 64'(exp_pack));
            end

            // hand-computed anchor points
            case (k)
                3:  check("lit_fs_frame0", k, 64'(frame_start), 64'd1);
                5:  check("lit_pix_0_0", k, 64'(pack), 64'h9102_0300);
                10: check("lit_hsync", k, 64'(pack), 64'hC000_0000);
                16: check("lit_pix_3_1", k, 64'(pack), 64'h9132_333D);
                37: check("lit_vsync", k, 64'(pack), 64'hA000_0000);
                51: check("lit_fs_frame1", k, 64'(frame_start), 64'd1);
                62: begin
                        check("lit_req_off", k, 64'(req), 64'd0);
                        check("lit_drain_pix", k, 64'(pack), 64'h9112_1315);
                    end
                63: check("lit_drained_idle", k, 64'(pack), 64'h8000_0000);
                66: check("lit_fs_reenable", k, 64'(frame_start), 64'd1);
                68: check("lit_rst_idle", k, 64'(pack), 64'h8000_0000);
                70: check("lit_fs_after_rst", k, 64'(frame_start), 64'd1);
                default: ;
            endcase

            @(posedge clk);
            if (rk || !ek) begin
                hc = 0; vc = 0;
            end else begin
                hc = hc + 1;
                if (hc == int'(HT)) begin
                    hc = 0;
                    vc = (vc + 1) % int'(VT);
                end
            end
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
